operand_align_pipe: RTL and testbench
=====================================

// Module: operand_align_pipe
// PURPOSE
//  Two-stage pipelined operand front end for the FP adder datapath, generalised to any IEEE-754-style format.
//  - Decomposes and classifies both operands.
//  - Orders them by magnitude and right-aligns the smaller mantissa with guard bits and sticky.
//  - Sits between the issue interface and the add/sub mantissa core; valid/ready on both sides.
// PARAMETERS
//  EXP_W    8   exponent field width
//  FRAC_W   23  stored fraction width; operand width W = 1+EXP_W+FRAC_W
//  GUARD_W  3   extra LSBs on aligned mantissa (guard, round, sticky; sticky is LSB); >=1
// PORTS
//  clk_i          in   1              clock, all state on rising edge
//  rst_ni         in   1              synchronous reset, active-low
//  valid_i        in   1              operand pair valid
//  ready_o        out  1              block accepts pair this cycle
//  x_i            in   W              operand x
//  y_i            in   W              operand y
//  valid_o        out  1              result valid
//  ready_i        in   1              downstream accepts result
//  swapped_o      out  1              1: |y|>|x|, big=y; 0 otherwise (incl. equal)
//  big_sign_o     out  1              sign of larger-magnitude operand
//  small_sign_o   out  1              sign of smaller-magnitude operand
//  big_exp_o      out  EXP_W          effective exponent of larger operand
//  exp_diff_o     out  EXP_W          big effective exp minus small effective exp
//  big_mant_o     out  FRAC_W+1       {hidden, frac} of larger operand
//  small_mant_o   out  FRAC_W+1+GUARD_W  {hidden,frac,0..} >> exp_diff, sticky ORed into LSB
//  inf_o          out  1              either operand is infinity
//  nan_o          out  1              either operand is NaN
//  snan_o         out  1              either operand is signalling NaN (frac MSB=0)
//  x_zero_o       out  1              x is zero (after flush, see CONFIGURATION)
//  y_zero_o       out  1              y is zero (after flush)
// BEHAVIOUR
//  - Reset (rst_ni=0 at edge): both stage valids 0, all registered outputs 0; in-flight data discarded.
//  - Stage S1 registers: signs, exps, fracs, class flags, magnitude compare ({exp,frac} unsigned), exp_diff.
//  - Stage S2 registers: ordered fields, shifted small mantissa + sticky; drives all outputs.
//  - Latency 2 cycles valid_i&ready_o -> valid_o when ready_i held 1; throughput 1 pair/cycle.
//  - Advance: en2 = !valid_o | ready_i; en1 = !s1_valid | en2; ready_o = en1 (combinational from ready_i).
//  - Bubbles collapse: an empty S1/S2 slot is filled even while downstream stalls.
//  - Outputs stable while valid_o & !ready_i; results in strict issue order, none dropped or duplicated.
//  - Hidden bit = 1 iff exp != 0. Effective exponent = exp, except exp==0 handled per CONFIGURATION.
//  - Shift: if exp_diff >= FRAC_W+1+GUARD_W, small_mant_o = {0.., |small_mant}; else logical
//    right shift, LSB |= OR of bits shifted out.
//  - Class: inf = exp all-ones & frac==0; NaN = exp all-ones & frac!=0; flags OR'd across x,y.
//    Inf and NaN may both be 1; consumer gives NaN priority. Datapath fields still computed for specials.
// CONFIGURATION
//  OPERAND_ALIGN_SUBNORM_EN defined: exp==0 operands are subnormal, effective exp=1, hidden=0;
//    zero flag only when exp==0 & frac==0.
//  Not defined: exp==0 operands flushed to zero (frac forced 0, effective exp 0, sign kept), zero flag=1.
// TESTING (FP32 defaults)
//  1 x=0x40400000,y=0x3F800000 -> 2 cyc later swapped=0,big_exp=0x80,exp_diff=1,
//    big_mant=0xC00000,small_mant=0x2000000
//  2 x=0x3F800000,y=0x40400000 -> swapped=1,big_sign=0,big_mant=0xC00000,small_mant=0x2000000
//  3 x=0x4B800000,y=0x33800001 -> exp_diff=0x30,small_mant=0x0000001 (sticky only)
//  4 x=0x7F800000,y=0x7FA00000 -> inf=1,nan=1,snan=1; x=0x7FC00000,y=0 -> nan=1,snan=0
//  5 stream 4 pairs, ready_i=0 cycles 3-5 -> ready_o=0 once S1,S2 full, 4 results in order, none lost
//  6 x=0x00000001,y=0: SUBNORM_EN -> big_exp=1,big_mant=0x000001,x_zero=0;
//    without -> x_zero=y_zero=1,big_mant=0; reset mid-stream -> valid_o=0 next cycle

Source files
------------

// File: rtl/operand_align_pipe.sv
// Two-stage FP adder operand front end: classify, order by magnitude, right-align smaller mantissa.
// Build option: define OPERAND_ALIGN_SUBNORM_EN to keep subnormals (default flushes exp==0 operands to zero).
module operand_align_pipe #(
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned FRAC_W  = 23,
    parameter int unsigned GUARD_W = 3,
    localparam int unsigned W      = 1 + EXP_W + FRAC_W,
    localparam int unsigned MANT_W = FRAC_W + 1,
    localparam int unsigned SMW    = MANT_W + GUARD_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [W-1:0]      x_i,
    input  logic [W-1:0]      y_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              swapped_o,
    output logic              big_sign_o,
    output logic              small_sign_o,
    output logic [EXP_W-1:0]  big_exp_o,
    output logic [EXP_W-1:0]  exp_diff_o,
    output logic [MANT_W-1:0] big_mant_o,
    output logic [SMW-1:0]    small_mant_o,
    output logic              inf_o,
    output logic              nan_o,
    output logic              snan_o,
    output logic              x_zero_o,
    output logic              y_zero_o
);

    localparam int unsigned KEY_W = EXP_W + FRAC_W;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp_eff;
        logic [MANT_W-1:0] mant;
        logic [KEY_W-1:0]  key;
        logic              inf;
        logic              nan;
        logic              snan;
        logic              zero;
    } op_t;

    typedef struct packed {
        logic              x_sign;
        logic              y_sign;
        logic [EXP_W-1:0]  x_exp;
        logic [EXP_W-1:0]  y_exp;
        logic [MANT_W-1:0] x_mant;
        logic [MANT_W-1:0] y_mant;
        logic              inf;
        logic              nan;
        logic              snan;
        logic              x_zero;
        logic              y_zero;
        logic              swap;
        logic [EXP_W-1:0]  exp_diff;
    } s1_t;

    typedef struct packed {
        logic              swapped;
        logic              big_sign;
        logic              small_sign;
        logic [EXP_W-1:0]  big_exp;
        logic [EXP_W-1:0]  exp_diff;
        logic [MANT_W-1:0] big_mant;
        logic [SMW-1:0]    small_mant;
        logic              inf;
        logic              nan;
        logic              snan;
        logic              x_zero;
        logic              y_zero;
    } s2_t;

    // Split one operand into effective fields, magnitude key and class flags.
    function automatic op_t decode(input logic [W-1:0] v);
        op_t               d;
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        logic              e_max;
        logic              e_zero;
        logic              f_nz;
        d      = '0;
        e      = v[W-2 -: EXP_W];
        f      = v[FRAC_W-1:0];
        e_max  = &e;
        e_zero = ~|e;
        f_nz   = |f;
        d.sign = v[W-1];
        d.inf  = e_max & ~f_nz;
        d.nan  = e_max & f_nz;
        d.snan = e_max & f_nz & ~f[FRAC_W-1];
`ifdef OPERAND_ALIGN_SUBNORM_EN
        d.exp_eff = e_zero ? EXP_W'(1) : e;
        d.zero    = e_zero & ~f_nz;
`else
        if (e_zero) begin
            f = '0;
        end
        d.exp_eff = e;
        d.zero    = e_zero;
`endif
        d.mant = {~e_zero, f};
        d.key  = {e, f};
        return d;
    endfunction

    logic       s1_valid_q, s1_valid_d;
    logic       s2_valid_q, s2_valid_d;
    s1_t        s1_q, s1_d;
    s2_t        s2_q, s2_d;
    logic       en1, en2;

    op_t        x_dec, y_dec;
    logic       swap;

    logic [SMW-1:0] ext;
    logic [SMW-1:0] lost_mask;
    logic [SMW-1:0] shifted;

    // A stage advances when it is empty or its successor is moving.
    assign en2     = ~s2_valid_q | ready_i;
    assign en1     = ~s1_valid_q | en2;
    assign ready_o = en1;

    // Stage 1: decode, classify, compare magnitudes.
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        x_dec      = decode(x_i);
        y_dec      = decode(y_i);
        swap       = y_dec.key > x_dec.key;
        if (en1) begin
            s1_valid_d = valid_i;
            if (valid_i) begin
                s1_d.x_sign   = x_dec.sign;
                s1_d.y_sign   = y_dec.sign;
                s1_d.x_exp    = x_dec.exp_eff;
                s1_d.y_exp    = y_dec.exp_eff;
                s1_d.x_mant   = x_dec.mant;
                s1_d.y_mant   = y_dec.mant;
                s1_d.inf      = x_dec.inf | y_dec.inf;
                s1_d.nan      = x_dec.nan | y_dec.nan;
                s1_d.snan     = x_dec.snan | y_dec.snan;
                s1_d.x_zero   = x_dec.zero;
                s1_d.y_zero   = y_dec.zero;
                s1_d.swap     = swap;
                s1_d.exp_diff = swap ? (y_dec.exp_eff - x_dec.exp_eff)
                                     : (x_dec.exp_eff - y_dec.exp_eff);
            end
        end
    end

    // Stage 2: order operands and align the smaller mantissa with sticky.
    always_comb begin
        s2_d       = s2_q;
        s2_valid_d = s2_valid_q;
        ext        = {(s1_q.swap ? s1_q.x_mant : s1_q.y_mant), {GUARD_W{1'b0}}};
        lost_mask  = ~({SMW{1'b1}} << s1_q.exp_diff);
        if (32'(s1_q.exp_diff) >= SMW) begin
            shifted = {{(SMW-1){1'b0}}, |ext};
        end else begin
            shifted = (ext >> s1_q.exp_diff) | {{(SMW-1){1'b0}}, |(ext & lost_mask)};
        end
        if (en2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d.swapped    = s1_q.swap;
                s2_d.big_sign   = s1_q.swap ? s1_q.y_sign : s1_q.x_sign;
                s2_d.small_sign = s1_q.swap ? s1_q.x_sign : s1_q.y_sign;
                s2_d.big_exp    = s1_q.swap ? s1_q.y_exp  : s1_q.x_exp;
                s2_d.exp_diff   = s1_q.exp_diff;
                s2_d.big_mant   = s1_q.swap ? s1_q.y_mant : s1_q.x_mant;
                s2_d.small_mant = shifted;
                s2_d.inf        = s1_q.inf;
                s2_d.nan        = s1_q.nan;
                s2_d.snan       = s1_q.snan;
                s2_d.x_zero     = s1_q.x_zero;
                s2_d.y_zero     = s1_q.y_zero;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign valid_o      = s2_valid_q;
    assign swapped_o    = s2_q.swapped;
    assign big_sign_o   = s2_q.big_sign;
    assign small_sign_o = s2_q.small_sign;
    assign big_exp_o    = s2_q.big_exp;
    assign exp_diff_o   = s2_q.exp_diff;
    assign big_mant_o   = s2_q.big_mant;
    assign small_mant_o = s2_q.small_mant;
    assign inf_o        = s2_q.inf;
    assign nan_o        = s2_q.nan;
    assign snan_o       = s2_q.snan;
    assign x_zero_o     = s2_q.x_zero;
    assign y_zero_o     = s2_q.y_zero;

endmodule

// File: tb/tb_operand_align_pipe.sv
// Scoreboard bench for operand_align_pipe (FP32): directed cases, stall/reset scenarios, random traffic.
module tb_operand_align_pipe;

    typedef struct packed {
        logic        swapped;
        logic        big_sign;
        logic        small_sign;
        logic [7:0]  big_exp;
        logic [7:0]  exp_diff;
        logic [23:0] big_mant;
        logic [26:0] small_mant;
        logic        inf;
        logic        nan;
        logic        snan;
        logic        x_zero;
        logic        y_zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_o, valid_o, ready_i;
    logic [31:0] x_i, y_i;
    logic        swapped_o, big_sign_o, small_sign_o;
    logic [7:0]  big_exp_o, exp_diff_o;
    logic [23:0] big_mant_o;
    logic [26:0] small_mant_o;
    logic        inf_o, nan_o, snan_o, x_zero_o, y_zero_o;
    res_t        act;

    int   checks   = 0;
    int   failures = 0;
    int   n_out    = 0;
    res_t exp_q[$];
    res_t held;
    logic rand_done;

    operand_align_pipe dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .x_i(x_i), .y_i(y_i), .valid_o(valid_o), .ready_i(ready_i),
        .swapped_o(swapped_o), .big_sign_o(big_sign_o), .small_sign_o(small_sign_o),
        .big_exp_o(big_exp_o), .exp_diff_o(exp_diff_o), .big_mant_o(big_mant_o),
        .small_mant_o(small_mant_o), .inf_o(inf_o), .nan_o(nan_o), .snan_o(snan_o),
        .x_zero_o(x_zero_o), .y_zero_o(y_zero_o)
    );

    always #5 clk = ~clk;

    assign act = {swapped_o, big_sign_o, small_sign_o, big_exp_o, exp_diff_o, big_mant_o,
                  small_mant_o, inf_o, nan_o, snan_o, x_zero_o, y_zero_o};

    // Reference: IEEE-style decode and alignment using plain integer arithmetic.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
        res_t   r;
        longint xe, ye, xf, yf, xeff, yeff, xm, ym, xmag, ymag;
        longint be, se, bm, sm, diff, ext, p, q;
        logic   xz, yz, xn, yn, xi, yi, xs, ys;
        xe = longint'(x[30:23]); ye = longint'(y[30:23]);
        xf = longint'(x[22:0]);  yf = longint'(y[22:0]);
        xi = (xe == 255) && (xf == 0); yi = (ye == 255) && (yf == 0);
        xn = (xe == 255) && (xf != 0); yn = (ye == 255) && (yf != 0);
        xs = xn && (xf < 4194304);     ys = yn && (yf < 4194304);
`ifdef OPERAND_ALIGN_SUBNORM_EN
        xeff = (xe == 0) ? 1 : xe;  yeff = (ye == 0) ? 1 : ye;
        xz = (xe == 0) && (xf == 0); yz = (ye == 0) && (yf == 0);
`else
        if (xe == 0) xf = 0;
        if (ye == 0) yf = 0;
        xeff = xe; yeff = ye;
        xz = (xe == 0); yz = (ye == 0);
`endif
        xm = ((xe != 0) ? 8388608 : 0) + xf;
        ym = ((ye != 0) ? 8388608 : 0) + yf;
        xmag = xe * 8388608 + xf;
        ymag = ye * 8388608 + yf;
        r = '0;
        r.swapped = ymag > xmag;
        if (r.swapped) begin
            be = yeff; se = xeff; bm = ym; sm = xm;
            r.big_sign = y[31]; r.small_sign = x[31];
        end else begin
            be = xeff; se = yeff; bm = xm; sm = ym;
            r.big_sign = x[31]; r.small_sign = y[31];
        end
        diff = be - se;
        ext  = sm * 8;
        if (diff >= 27) begin
            q = (ext != 0) ? 1 : 0;
        end else begin
            p = 1;
            for (longint k = 0; k < diff; k++) p = p * 2;
            q = ext / p;
            if (q * p != ext) q = q | 1;
        end
        r.big_exp    = 8'(be);
        r.exp_diff   = 8'(diff);
        r.big_mant   = 24'(bm);
        r.small_mant = 27'(q);
        r.inf        = xi || yi;
        r.nan        = xn || yn;
        r.snan       = xs || ys;
        r.x_zero     = xz;
        r.y_zero     = yz;
        return r;
    endfunction

    function automatic res_t mk(input logic sw, input logic bs, input logic ss,
                                input logic [7:0] be, input logic [7:0] ed,
                                input logic [23:0] bm, input logic [26:0] sm,
                                input logic inf, input logic nan, input logic snan,
                                input logic xz, input logic yz);
        return {sw, bs, ss, be, ed, bm, sm, inf, nan, snan, xz, yz};
    endfunction

    function automatic logic [31:0] rand_op(input logic [7:0] near);
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0:       v[30:23] = 8'h00;
            1:       v[30:23] = 8'hFF;
            2:       v[22:0]  = '0;
            3, 4, 5: v[30:23] = near + 8'($urandom_range(0, 40)) - 8'd20;
            default: ;
        endcase
        return v;
    endfunction

    task automatic check1(input string name, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, a, e);
        end
    endtask

    // Called on a negedge; returns on the negedge after the pair is accepted.
    task automatic send_exp(input logic [31:0] x, input logic [31:0] y, input res_t e);
        int n;
        n = 0;
        valid_i = 1'b1; x_i = x; y_i = y;
        #2;
        while (!ready_o && n < 500) begin
            @(negedge clk); #2; n++;
        end
        if (ready_o) begin
            exp_q.push_back(e);
        end else begin
            checks++; failures++;
            $display("FAIL send_timeout actual ready_o=0 required ready_o=1");
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y);
        send_exp(x, y, model(x, y));
    endtask

    task automatic drain();
        int n;
        n = 0;
        valid_i = 1'b0; ready_i = 1'b1;
        while ((exp_q.size() != 0 || valid_o) && n < 200) begin
            @(negedge clk); #2; n++;
        end
        checks++;
        if (exp_q.size() != 0 || valid_o) begin
            failures++;
            $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
        end
        @(negedge clk);
    endtask

    // Monitor: a transfer happens at the next posedge when valid_o & ready_i are seen here.
    initial begin : monitor
        forever begin
            @(negedge clk); #2;
            if (rst_n && valid_o && ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output actual=%h required=none", act);
                end else begin
                    held = exp_q.pop_front();
                    if (act !== held) begin
                        failures++;
                        $display("FAIL result_%0d actual=%h required=%h", n_out, act, held);
                    end
                end
                n_out++;
            end
        end
    end

    initial begin : stim
        res_t stall_snap;
        logic [31:0] rx, ry;
        rst_n = 1'b0; valid_i = 1'b0; x_i = '0; y_i = '0; ready_i = 1'b1;
        rand_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #2;
        check1("reset_valid_o", valid_o, 1'b0);
        check1("reset_ready_o", ready_o, 1'b1);
        checks++;
        if (act !== '0) begin
            failures++;
            $display("FAIL reset_outputs actual=%h required=0", act);
        end
        @(negedge clk);

        // Directed cases with hand-derived expectations.
        send_exp(32'h40400000, 32'h3F800000, mk(0, 0, 0, 8'h80, 8'h01, 24'hC00000, 27'h2000000, 0, 0, 0, 0, 0));
        send_exp(32'h3F800000, 32'h40400000, mk(1, 0, 0, 8'h80, 8'h01, 24'hC00000, 27'h2000000, 0, 0, 0, 0, 0));
        send_exp(32'h4B800000, 32'h33800001, mk(0, 0, 0, 8'h97, 8'h30, 24'h800000, 27'h0000001, 0, 0, 0, 0, 0));
        send_exp(32'h7F800000, 32'h7FA00000, mk(1, 0, 0, 8'hFF, 8'h00, 24'hA00000, 27'h4000000, 1, 1, 1, 0, 0));
`ifdef OPERAND_ALIGN_SUBNORM_EN
        send_exp(32'h7FC00000, 32'h00000000, mk(0, 0, 0, 8'hFF, 8'hFE, 24'hC00000, 27'h0, 0, 1, 0, 0, 1));
        send_exp(32'h00000001, 32'h00000000, mk(0, 0, 0, 8'h01, 8'h00, 24'h000001, 27'h0, 0, 0, 0, 0, 1));
`else
        send_exp(32'h7FC00000, 32'h00000000, mk(0, 0, 0, 8'hFF, 8'hFF, 24'hC00000, 27'h0, 0, 1, 0, 0, 1));
        send_exp(32'h00000001, 32'h00000000, mk(0, 0, 0, 8'h00, 8'h00, 24'h000000, 27'h0, 0, 0, 0, 1, 1));
`endif
        send_exp(32'hC0400000, 32'h3F800000, mk(0, 1, 0, 8'h80, 8'h01, 24'hC00000, 27'h2000000, 0, 0, 0, 0, 0));
        drain();

        // Stream four pairs into a stalled sink: pipe fills, ready_o drops, outputs hold.
        ready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(rand_op(8'h80), rand_op(8'h80));
                valid_i = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                #2;
                check1("stall_ready_o", ready_o, 1'b0);
                check1("stall_valid_o", valid_o, 1'b1);
                stall_snap = act;
                repeat (2) @(negedge clk);
                #1;
                checks++;
                if (act !== stall_snap) begin
                    failures++;
                    $display("FAIL stall_hold actual=%h required=%h", act, stall_snap);
                end
                ready_i = 1'b1;
            end
        join
        drain();

        // Randomized traffic with random backpressure and input bubbles.
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    rx = rand_op(8'($urandom));
                    ry = rand_op(rx[30:23]);
                    if ($urandom_range(0, 4) == 0) begin
                        valid_i = 1'b0;
                        @(negedge clk);
                    end
                    send(rx, ry);
                end
                valid_i = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    ready_i = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                end
                ready_i = 1'b1;
            end
        join
        drain();

        // Reset with data in flight discards it.
        ready_i = 1'b0;
        send(32'h41200000, 32'h40000000);
        send(32'h3F000000, 32'hBF800000);
        valid_i = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        #2;
        check1("midreset_valid_o", valid_o, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        ready_i = 1'b1;
        #2;
        check1("postreset_ready_o", ready_o, 1'b1);
        @(negedge clk);
        send(32'h40400000, 32'h3F800000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
